seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 8-digit 7-segment display interface: the end that watches the lines instead of driving them.
- Watches SEG_COM (active-low one-hot digit select) and SEG7 (segments a..g, active-high, a = bit 6).
- Rebuilds the 8 BCD digits and publishes a complete frame once digits 0..7 have been seen in order.
- Used as an on-board display monitor and as the checker for display-driver blocks; samples the bus on its own faster clock.

Parameters:
STABLE_CYC, 2, consecutive identical synchronised samples required before a sample is accepted (1..15)

Ports:
C  input  1  clock; all logic on rising edge
R  input  1  reset, synchronous, active-high
SEG_COM  input  8  digit select, bit k low = digit k shown; asynchronous to C
SEG7  input  7  segment pattern {a,b,c,d,e,f,g}; asynchronous to C
CLR  input  1  synchronous clear of sticky ERR bits
DIGITS  output  32  last complete frame; digit k in bits [4k+3:4k], digit 0 least significant
VALID  output  1  at least one complete frame captured since reset
FRAME  output  1  one-cycle pulse; DIGITS updated this cycle
ERR  output  3  sticky {seq, com, seg}

Behaviour:
- Reset (R=1 at rising C):
  - DIGITS=0, VALID=0, FRAME=0, ERR=0.
  - FSM=HUNT, stab_cnt=0, exp=0, working digits=0.
  - Synchroniser stages load COM=8'hFF, SEG=7'h00.
  - R takes priority over CLR and over any accept in the same cycle.
- Input path:
  - 2-flop synchroniser on {SEG_COM,SEG7}.
  - Third register holds the previous synchronised sample.
- Stability:
  - stab_cnt clears to 0 when the synchronised sample differs from the previous sample.
  - Otherwise it increments, saturating at STABLE_CYC.
  - An accept fires in exactly the cycle stab_cnt becomes STABLE_CYC, so one accept per stable period.
  - Latency from a pin change to accept: 2 + STABLE_CYC cycles.
- Accept classification:
  - COM all ones (blank): ignored; no write, no error.
  - COM exactly one bit low, index k: digit event.
  - Any other COM: set ERR[1] (com); FSM returns to HUNT.
- Segment decode:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9.
  - 00 (blank) → 4'hF and sets ERR[0].
  - Any other pattern → 4'hE and sets ERR[0].
  - The decoded nibble is still written.
- FSM HUNT:
  - Digit event with k=0: write working[0], exp=1, go to COLLECT.
  - Any other k: ignored, no error.
- FSM COLLECT:
  - k==exp: write working[k], exp=exp+1.
  - k==exp==7: next cycle DIGITS<=working with digit 7 included, FRAME=1, VALID=1, exp=0, stay in COLLECT.
  - k==exp-1 (same digit re-accepted after a blank gap): ignored.
  - k==0 with exp≠0: restart the frame, write working[0], exp=1, set ERR[2] (seq).
  - Any other k: set ERR[2], go to HUNT.
- Output timing:
  - FRAME is high exactly 1 cycle, the cycle after the digit-7 accept.
  - DIGITS holds its value between frames.
  - DIGITS changes only together with FRAME or on reset.
- ERR:
  - Sticky once set.
  - CLR=1 clears all three bits.
  - If CLR and a new error coincide in the same cycle, the new error wins (bit ends at 1).

Optional Feature:
SEG_BLANK_ZERO_EN
- Defined: pattern 7'h00 decodes to 4'h0 without setting ERR[0]. This accepts leading-zero-blanked displays.
- Undefined: 7'h00 decodes to 4'hF and sets ERR[0], as above.

Test Plan:
- Reset then idle (COM=FF): hold 50 cycles → DIGITS=0, VALID=0, FRAME never 1, ERR=0.
- Driver model shows 0x00000123, each digit held 8 cycles, order 0..7 → FRAME pulse about 2+2 cycles after digit 7 appears; DIGITS=32'h00000123, VALID=1, ERR=0.
- Same scan sequence with a 1-cycle glitch inserted in each digit (STABLE_CYC=2) → glitch never accepted; same DIGITS, ERR=0.
- Sequence 0,1,2,5 → ERR=3'b100, FSM in HUNT; a following clean 0..7 frame of 0x87654321 → DIGITS=32'h87654321; ERR stays 3'b100 until CLR pulse, then 0.
- COM=8'hF0 held 4 cycles → ERR[1]=1, no write. SEG7=7'h00 on digit 3:
  - Macro undefined → DIGITS[15:12]=F, ERR[0]=1.
  - Macro defined → DIGITS[15:12]=0, ERR[0]=0.
- R asserted mid-frame after digit 4 → next cycle all outputs 0, FSM in HUNT; a frame resuming at digit 5 is ignored until digit 0 appears.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor for a multiplexed 8-digit 7-segment bus; rebuilds BCD frames.
// Optional macro SEG_BLANK_ZERO_EN: blank pattern 7'h00 decodes to 0 with no segment error.
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic        C,
  input  logic        R,
  input  logic [7:0]  SEG_COM,
  input  logic [6:0]  SEG7,
  input  logic        CLR,
  output logic [31:0] DIGITS,
  output logic        VALID,
  output logic        FRAME,
  output logic [2:0]  ERR
);

  typedef enum logic [0:0] {HUNT = 1'b0, COLLECT = 1'b1} state_e;

  localparam logic [3:0]  STAB_MAX   = 4'(STABLE_CYC);
  localparam logic [14:0] SAMPLE_RST = {8'hFF, 7'h00};

  logic [14:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0]  stab_cnt_q, stab_cnt_d;
  state_e      state_q, state_d;
  logic [2:0]  exp_q, exp_d;
  logic [31:0] work_q, work_d;
  logic [31:0] digits_q, digits_d;
  logic        valid_q, valid_d;
  logic        frame_q, frame_d;
  logic [2:0]  err_q, err_d;

  logic        accept;
  logic [7:0]  com_low;
  logic [2:0]  digit_idx;
  logic [4:0]  dec;
  logic        wr;
  logic [2:0]  err_set;

  // Returns {segment_error, nibble}; unknown patterns still yield a nibble to write.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   seg_decode = 5'b0_0000;
      7'h30:   seg_decode = 5'b0_0001;
      7'h6D:   seg_decode = 5'b0_0010;
      7'h79:   seg_decode = 5'b0_0011;
      7'h33:   seg_decode = 5'b0_0100;
      7'h5B:   seg_decode = 5'b0_0101;
      7'h5F:   seg_decode = 5'b0_0110;
      7'h70:   seg_decode = 5'b0_0111;
      7'h7F:   seg_decode = 5'b0_1000;
      7'h73:   seg_decode = 5'b0_1001;
`ifdef SEG_BLANK_ZERO_EN
      7'h00:   seg_decode = 5'b0_0000;
`else
      7'h00:   seg_decode = 5'b1_1111;
`endif
      default: seg_decode = 5'b1_1110;
    endcase
  endfunction

  // Two-stage synchroniser plus the previous-sample register.
  always_comb begin
    sync1_d = {SEG_COM, SEG7};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Stability counter, accept detection, digit sequencing and error collection.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    state_d    = state_q;
    exp_d      = exp_q;
    work_d     = work_q;
    digits_d   = digits_q;
    valid_d    = valid_q;
    frame_d    = 1'b0;
    wr         = 1'b0;
    err_set    = 3'b000;
    digit_idx  = 3'd0;
    com_low    = ~sync2_q[14:7];
    dec        = seg_decode(sync2_q[6:0]);

    if (sync2_q != prev_q) begin
      stab_cnt_d = 4'd0;
    end else if (stab_cnt_q < STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 4'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
    // Only the transition into saturation accepts, giving one accept per stable period.
    accept = (stab_cnt_d == STAB_MAX) && (stab_cnt_q != STAB_MAX);

    for (int i = 0; i < 8; i++) begin
      if (com_low[i]) digit_idx = 3'(i);
      else            digit_idx = digit_idx;
    end

    if (accept && (com_low != 8'h00)) begin
      if (!$onehot(com_low)) begin
        err_set[1] = 1'b1;
        state_d    = HUNT;
      end else begin
        case (state_q)
          HUNT: begin
            if (digit_idx == 3'd0) begin
              wr      = 1'b1;
              exp_d   = 3'd1;
              state_d = COLLECT;
            end else begin
              state_d = HUNT;
            end
          end
          COLLECT: begin
            if (digit_idx == exp_q) begin
              wr = 1'b1;
              if (digit_idx == 3'd7) begin
                digits_d = {dec[3:0], work_q[27:0]};
                frame_d  = 1'b1;
                valid_d  = 1'b1;
                exp_d    = 3'd0;
              end else begin
                exp_d = exp_q + 3'd1;
              end
            end else if (digit_idx == exp_q - 3'd1) begin
              exp_d = exp_q;
            end else if (digit_idx == 3'd0) begin
              wr         = 1'b1;
              exp_d      = 3'd1;
              err_set[2] = 1'b1;
            end else begin
              err_set[2] = 1'b1;
              state_d    = HUNT;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (wr) begin
      work_d[{digit_idx, 2'b00} +: 4] = dec[3:0];
      err_set[0]                      = dec[4];
    end else begin
      err_set[0] = 1'b0;
    end

    // A new error beats a simultaneous clear.
    err_d = (CLR ? 3'b000 : err_q) | err_set;
  end

  // State register with synchronous reset taking priority over everything else.
  always_ff @(posedge C) begin
    if (R) begin
      sync1_q    <= SAMPLE_RST;
      sync2_q    <= SAMPLE_RST;
      prev_q     <= SAMPLE_RST;
      stab_cnt_q <= 4'd0;
      state_q    <= HUNT;
      exp_q      <= 3'd0;
      work_q     <= 32'h0000_0000;
      digits_q   <= 32'h0000_0000;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      work_q     <= work_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign DIGITS = digits_q;
  assign VALID  = valid_q;
  assign FRAME  = frame_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised bench for seg7_scan_capture against a window-based behavioural model.
// Honours SEG_BLANK_ZERO_EN the same way the design does.
module tb_seg7_scan_capture;

  localparam int S = 2;
  localparam logic [6:0] SEG_TAB [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic [7:0]  SEG_COM = 8'hFF;
  logic [6:0]  SEG7 = 7'h00;
  logic        CLR = 1'b0;
  logic [31:0] DIGITS;
  logic        VALID;
  logic        FRAME;
  logic [2:0]  ERR;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference state
  int          cyc = 100;
  logic [15:0] hist [64];
  bit          m_hunt;
  int          m_exp;
  logic [3:0]  m_work [8];
  logic [31:0] m_digits;
  logic        m_valid, m_frame;
  logic [2:0]  m_err;

  seg7_scan_capture #(.STABLE_CYC(S)) dut (
    .C(C), .R(R), .SEG_COM(SEG_COM), .SEG7(SEG7), .CLR(CLR),
    .DIGITS(DIGITS), .VALID(VALID), .FRAME(FRAME), .ERR(ERR)
  );

  always #5 C = ~C;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) if (SEG_TAB[d] == seg) return {1'b0, 4'(d)};
`ifdef SEG_BLANK_ZERO_EN
    if (seg == 7'h00) return 5'h00;
`else
    if (seg == 7'h00) return 5'h1F;
`endif
    return 5'h1E;
  endfunction

  // A pin value is accepted once it has been sampled S+1 times in a row after a change,
  // and takes effect 2 edges after the last of those samples.
  function automatic bit fresh_accept(input int e);
    logic [15:0] v;
    v = hist[(e - 2) % 64];
    for (int i = e - 2 - S; i < e - 2; i++) if (hist[i % 64] != v) return 1'b0;
    return hist[(e - 3 - S) % 64] != v;
  endfunction

  task automatic model_step();
    logic [15:0] v;
    logic [4:0]  d;
    logic [2:0]  nerr;
    int          k;
    cyc++;
    hist[cyc % 64] = {1'b0, SEG_COM, SEG7};
    if (R) begin
      hist[cyc % 64]       = {1'b0, 8'hFF, 7'h00};
      hist[(cyc - 1) % 64] = {1'b0, 8'hFF, 7'h00};
      hist[(cyc - 2) % 64] = {1'b0, 8'hFF, 7'h00};
      hist[(cyc - 3) % 64] = 16'h8000;
      m_hunt = 1'b1; m_exp = 0; m_digits = 32'h0; m_valid = 1'b0; m_frame = 1'b0; m_err = 3'b000;
      for (int i = 0; i < 8; i++) m_work[i] = 4'h0;
      return;
    end
    m_frame = 1'b0;
    nerr = 3'b000;
    if (fresh_accept(cyc)) begin
      v = hist[(cyc - 2) % 64];
      d = ref_decode(v[6:0]);
      if (v[14:7] == 8'hFF) begin
        k = -1;
      end else if ($countones(~v[14:7]) != 1) begin
        nerr[1] = 1'b1;
        m_hunt  = 1'b1;
      end else begin
        k = 0;
        for (int i = 0; i < 8; i++) if (!v[7 + i]) k = i;
        if (m_hunt) begin
          if (k == 0) begin
            m_work[0] = d[3:0]; nerr[0] = d[4]; m_exp = 1; m_hunt = 1'b0;
          end
        end else if (k == m_exp) begin
          m_work[k] = d[3:0]; nerr[0] = d[4];
          if (k == 7) begin
            for (int i = 0; i < 8; i++) m_digits[4*i +: 4] = m_work[i];
            m_frame = 1'b1; m_valid = 1'b1; m_exp = 0;
          end else begin
            m_exp = m_exp + 1;
          end
        end else if (k == (m_exp + 7) % 8) begin
          // repeat of the digit just taken: nothing happens
        end else if (k == 0) begin
          m_work[0] = d[3:0]; nerr[0] = d[4]; m_exp = 1; nerr[2] = 1'b1;
        end else begin
          nerr[2] = 1'b1; m_hunt = 1'b1;
        end
      end
    end
    m_err = (CLR ? 3'b000 : m_err) | nerr;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) hist[i] = 16'h8000;
    forever begin
      @(posedge C);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge C);
      if (chk_en) begin
        check_val("digits", DIGITS, m_digits);
        check_val("valid", 32'(VALID), 32'(m_valid));
        check_val("frame", 32'(FRAME), 32'(m_frame));
        check_val("err", 32'(ERR), 32'(m_err));
      end
    end
  end

  task automatic show_raw(input logic [7:0] com, input logic [6:0] seg, input int hold);
    SEG_COM = com;
    SEG7    = seg;
    repeat (hold) @(negedge C);
  endtask

  task automatic show(input int k, input logic [3:0] nib, input int hold);
    show_raw(~(8'h01 << k), SEG_TAB[nib], hold);
  endtask

  task automatic show_frame(input logic [31:0] val, input bit glitch);
    for (int k = 0; k < 8; k++) begin
      if (glitch) begin
        show(k, val[4*k +: 4], 3);
        show_raw(~(8'h01 << k), SEG_TAB[val[4*k +: 4]] ^ 7'h01, 1);
        show(k, val[4*k +: 4], 4);
      end else begin
        show(k, val[4*k +: 4], 8);
      end
    end
    show_raw(8'hFF, 7'h00, 8);
  endtask

  initial begin
    int r;
    int nk;
    R = 1'b1;
    repeat (3) @(negedge C);
    chk_en = 1'b1;
    R = 1'b0;

    // Idle after reset
    repeat (50) @(negedge C);
    check_val("idle_digits", DIGITS, 32'h0);
    check_val("idle_valid", 32'(VALID), 32'h0);
    check_val("idle_err", 32'(ERR), 32'h0);

    // Clean frame, then the same frame with a one-cycle glitch per digit
    show_frame(32'h0000_0123, 1'b0);
    check_val("frame1_digits", DIGITS, 32'h0000_0123);
    check_val("frame1_valid", 32'(VALID), 32'h1);
    check_val("frame1_err", 32'(ERR), 32'h0);
    show_frame(32'h0000_0123, 1'b1);
    check_val("glitch_digits", DIGITS, 32'h0000_0123);
    check_val("glitch_err", 32'(ERR), 32'h0);

    // Out-of-order digit, recovery, clear
    show(0, 4'h1, 8); show(1, 4'h2, 8); show(2, 4'h3, 8); show(5, 4'h4, 8);
    show_raw(8'hFF, 7'h00, 8);
    check_val("seq_err", 32'(ERR), 32'h4);
    show_frame(32'h8765_4321, 1'b0);
    check_val("seq_digits", DIGITS, 32'h8765_4321);
    check_val("seq_err_sticky", 32'(ERR), 32'h4);
    CLR = 1'b1; @(negedge C); CLR = 1'b0;
    check_val("clr_err", 32'(ERR), 32'h0);

    // Illegal COM, then a blank digit 3
    show_raw(8'hF0, 7'h7E, 4);
    show_raw(8'hFF, 7'h00, 6);
    check_val("com_err", 32'(ERR[1]), 32'h1);
    check_val("com_nowrite", DIGITS, 32'h8765_4321);
    CLR = 1'b1; @(negedge C); CLR = 1'b0;
    show(0, 4'h1, 8); show(1, 4'h2, 8); show(2, 4'h3, 8);
    show_raw(8'hF7, 7'h00, 8);
    show(4, 4'h5, 8); show(5, 4'h6, 8); show(6, 4'h7, 8); show(7, 4'h8, 8);
    show_raw(8'hFF, 7'h00, 8);
`ifdef SEG_BLANK_ZERO_EN
    check_val("blank_digit", 32'(DIGITS[15:12]), 32'h0);
    check_val("blank_err", 32'(ERR[0]), 32'h0);
`else
    check_val("blank_digit", 32'(DIGITS[15:12]), 32'hF);
    check_val("blank_err", 32'(ERR[0]), 32'h1);
`endif

    // Reset mid-frame, then a frame resuming at digit 5
    for (int k = 0; k < 5; k++) show(k, 4'(k + 2), 8);
    R = 1'b1; SEG_COM = 8'hFF; SEG7 = 7'h00;
    @(negedge C);
    check_val("rst_digits", DIGITS, 32'h0);
    check_val("rst_valid", 32'(VALID), 32'h0);
    check_val("rst_err", 32'(ERR), 32'h0);
    R = 1'b0;
    show_raw(8'hFF, 7'h00, 6);
    show(5, 4'h1, 8); show(6, 4'h2, 8); show(7, 4'h3, 8);
    show_raw(8'hFF, 7'h00, 6);
    check_val("resume_valid", 32'(VALID), 32'h0);
    check_val("resume_err", 32'(ERR), 32'h0);
    show_frame(32'h2468_1357, 1'b0);
    check_val("resume_digits", DIGITS, 32'h2468_1357);

    // Randomised traffic, mostly in-order digits with assorted disturbances
    nk = 0;
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        if ($urandom_range(0, 9) == 0) nk = $urandom_range(0, 7);
        if ($urandom_range(0, 9) == 0)
          show_raw(~(8'h01 << nk), 7'($urandom), $urandom_range(1, 10));
        else
          show(nk, 4'($urandom_range(0, 9)), $urandom_range(1, 10));
        if ($urandom_range(0, 3) != 0) nk = (nk + 1) % 8;
      end else if (r < 78) begin
        show_raw(8'hFF, 7'h00, $urandom_range(1, 6));
      end else if (r < 86) begin
        show_raw(8'($urandom), 7'($urandom), $urandom_range(1, 6));
      end else if (r < 95) begin
        CLR = 1'b1; @(negedge C); CLR = 1'b0;
      end else if (r < 98) begin
        show_raw(~(8'h01 << nk), 7'h00, $urandom_range(1, 6));
      end else begin
        R = 1'b1; @(negedge C); R = 1'b0;
        nk = 0;
      end
    end
    show_raw(8'hFF, 7'h00, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
